// File: rtl/codec_adc_rx.sv
// Serial-audio ADC receiver: resynchronizes the codec's BCLK/LRCK/ADCDAT and
// emits one channel as a parallel sample with a single-cycle ready strobe.
module codec_adc_rx #(
    parameter int WIDTH   = 16,
    parameter int CHANNEL = 0,
    parameter int DELAY   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bclk,
    input  logic             lrck,
    input  logic             adcdat,
    output logic [WIDTH-1:0] SampleOut,
    output logic             ready,
    output logic             FrameErr
);

    localparam int             BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [BW-1:0]  BIT_INC   = BW'(1);
    localparam logic [1:0]     SKIP_LAST = 2'(DELAY - 1);
    localparam logic           CH_LVL    = 1'(CHANNEL);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [2:0]       bclk_q;
    logic [2:0]       lrck_q;
    logic [1:0]       adc_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       skip_q, skip_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             done_q, done_d;
    logic             ferr_d;
    logic [WIDTH-1:0] sample_q;
    logic             ready_q;
    logic             ferr_q;

    logic             bclk_rise_s;
    logic             lrck_edge_s;
    logic [WIDTH-1:0] shift_s;

    assign bclk_rise_s = bclk_q[1] & ~bclk_q[2];
    assign lrck_edge_s = lrck_q[1] ^ lrck_q[2];
    assign shift_s     = {sr_q[WIDTH-2:0], adc_q[1]};

    // Two-flop synchronizers plus one history flop for BCLK/LRCK edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_q <= 3'b000;
            lrck_q <= 3'b000;
            adc_q  <= 2'b00;
        end else begin
            bclk_q <= {bclk_q[1:0], bclk};
            lrck_q <= {lrck_q[1:0], lrck};
            adc_q  <= {adc_q[0], adcdat};
        end
    end

    // Frame FSM; an LRCK edge always wins over a coincident BCLK rise.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (lrck_edge_s) begin
            if ((state_q == ST_SKIP) || (state_q == ST_SHIFT)) begin
                ferr_d = 1'b1;
            end else begin
                ferr_d = 1'b0;
            end
            skip_d = 2'd0;
            bit_d  = '0;
            if (lrck_q[1] != CH_LVL) begin
                state_d = ST_IDLE;
            end else if (DELAY == 0) begin
                state_d = ST_SHIFT;
                if (bclk_rise_s) begin
                    sr_d  = shift_s;
                    bit_d = BIT_INC;
                end else begin
                    sr_d = sr_q;
                end
            end else if (bclk_rise_s && (DELAY == 1)) begin
                state_d = ST_SHIFT;
            end else if (bclk_rise_s) begin
                state_d = ST_SKIP;
                skip_d  = 2'd1;
            end else begin
                state_d = ST_SKIP;
            end
        end else if (bclk_rise_s) begin
            case (state_q)
                ST_SKIP: begin
                    if (skip_q == SKIP_LAST) begin
                        state_d = ST_SHIFT;
                        bit_d   = '0;
                    end else begin
                        skip_d = skip_q + 2'd1;
                    end
                end
                ST_SHIFT: begin
                    sr_d = shift_s;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_WAIT;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_INC;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM and shift-register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            skip_q  <= 2'd0;
            bit_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
        end
    end

    // Output register: sample and strobe update together one cycle after completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sample_q <= done_q ? sr_q : sample_q;
            ready_q  <= done_q;
            ferr_q   <= ferr_d;
        end
    end

    assign SampleOut = sample_q;
    assign ready     = ready_q;
    assign FrameErr  = ferr_q;

endmodule
